pipe_mux_nx1: RTL and testbench
===============================

Name: pipe_mux_nx1

Overview:
- Parametrised successor to the fixed 32-bit 2:1 datapath mux: an N-input, WIDTH-bit selector with a registered output stage.
- Uses a valid/ready handshake with a one-entry skid buffer, so it sustains one transfer per cycle with a fully registered in_ready.
- Sits between pipeline stages of the mini-MIPS datapath, e.g. ALU operand and forwarding select, and writeback source select.
- Flags out-of-range select codes instead of passing undefined data.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 4, number of data inputs; legal range 2..16.
- SELW, 2, select width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bus  input  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SELW  select code, sampled with in_valid.
- in_valid  input  1  upstream offers a beat.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts a beat.
- sel_err  output  1  sticky flag: an accepted beat had sel >= N.
- err_clr  input  1  synchronous clear for sel_err.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is asynchronous, active-low, named rst_n.
  - rst_n low forces: out_data=0, out_valid=0, skid empty (skid_data=0), in_ready=1, sel_err=0. This applies immediately, including mid-transfer; in-flight beats are discarded.
- Handshakes:
  - acc = in_valid & in_ready.
  - drn = out_valid & out_ready.
- Selected value D = in_bus[sel*WIDTH +: WIDTH] if sel < N, else all zeros. D is combinational from the current sel and in_bus.
- in_ready is a register and equals NOT skid_valid. It never depends combinationally on out_ready.
- Output register update, per clock:
  - out_valid=0, or drn: the output register loads the next beat. The source is skid if skid_valid, else D if acc. If neither is present, out_valid goes to 0.
  - out_valid=1 and not drn: out_data is held. An accepted beat goes to skid, and skid_valid becomes 1.
  - skid_valid=1 with drn: skid moves to the output and skid_valid becomes 0. in_ready is 0 in this state, so no simultaneous accept is possible.
- Latency:
  - 1 cycle from accept to out_valid when the output register is empty or draining.
  - Throughput is 1 beat/cycle with out_ready held high.
- Ordering is strictly FIFO; at most 2 beats are in flight.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- sel_err:
  - Set on any acc with sel >= N.
  - Cleared by err_clr=1.
  - Simultaneous set and clear: set wins.
  - Beats with sel unaccepted (acc=0) never affect sel_err.
- When N = 2**SELW, every sel is legal and sel_err stays 0.
- in_bus and sel are don't-care when acc=0.

Test Plan:
- Reset then stream, N=4, WIDTH=32:
  - Stimulus: in_bus = {0x44444444, 0x33333333, 0x22222222, 0x11111111}; sel 0,1,2,3 on consecutive cycles; in_valid=1, out_ready=1.
  - Required: out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles 1-4, each with out_valid=1. in_ready stays 1.
- Backpressure / skid:
  - Stimulus: out_ready=0 while 3 beats (sel=1,2,3) are offered.
  - Required: beat 1 sits in the output register and beat 2 in skid. in_ready drops to 0 the cycle after beat 2 is accepted. Beat 3 is held by upstream.
  - Then raise out_ready: outputs 0x22222222, 0x33333333, 0x44444444 in order with no loss or duplication.
- Out-of-range select:
  - Stimulus: N=3, SELW=2, sel=3 accepted.
  - Required: out_data=0x00000000, out_valid=1, sel_err=1 from the next cycle and sticky.
  - err_clr pulse: sel_err returns to 0.
  - err_clr coincident with another sel=3 accept: sel_err stays 1.
- Full-range select:
  - Stimulus: N=4, SELW=2, all sel values.
  - Required: sel_err never asserts.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously (between clock edges) with output and skid both full.
  - Required: immediately out_valid=0, out_data=0, in_ready=1, sel_err=0. After release, the first accepted beat appears 1 cycle later.
- Random handshake:
  - Stimulus: 1000 beats, random in_valid/out_ready, N=5, WIDTH=8, SELW=3.
  - Required: scoreboard of expected D values matches out_data exactly, in order. out_data is stable whenever out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/pipe_mux_nx1.sv
// pipe_mux_nx1: N-input, WIDTH-bit select mux with a registered output stage.
// A one-entry skid buffer behind the output register sustains one beat per
// cycle while keeping in_ready a pure register output. Select codes >= N
// produce zero data and raise a sticky sel_err flag.
module pipe_mux_nx1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_bus,
  input  logic [SELW-1:0]      sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err,
  input  logic                 err_clr
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic             acc;
  logic             drn;

  assign acc = in_valid & in_ready_q;
  assign drn = out_valid_q & out_ready;

  // Combinational select of the addressed input; illegal codes yield zero.
  always_comb begin
    sel_data = '0;
    sel_oob  = (32'(sel) >= N);
    for (int k = 0; k < N; k++) begin
      if (32'(sel) == k) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for output register, skid buffer, ready and error flag.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    sel_err_d    = sel_err_q;

    if (!out_valid_q || drn) begin
      // Output slot is free this cycle: the skid beat is older, so it goes
      // first. in_ready is low whenever skid is full, so no accept collides.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      // Output stalled: park the new beat in the skid buffer.
      skid_data_d  = sel_data;
      skid_valid_d = 1'b1;
    end

    // Ready is registered so it never depends on out_ready in the same cycle.
    in_ready_d = ~skid_valid_d;

    // Set has priority over clear.
    if (acc && sel_oob) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  // State registers; asynchronous reset discards any in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      sel_err_q    <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Testbench for pipe_mux_nx1: three instances (N=4/W=32, N=3/W=32,
// N=5/W=8) exercised by directed steps and a random handshake run.
module tb_pipe_mux_nx1;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Instance A: N=4, WIDTH=32, SELW=2 (full-range select)
  logic [127:0] in_bus4;
  logic [1:0]   sel4;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, sel_err4, err_clr4;
  logic [31:0]  out_data4;

  // Instance B: N=3, WIDTH=32, SELW=2 (sel=3 is illegal)
  logic [95:0]  in_bus3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3, err_clr3;
  logic [31:0]  out_data3;

  // Instance C: N=5, WIDTH=8, SELW=3 (random handshake)
  logic [39:0]  in_bus5;
  logic [2:0]   sel5;
  logic         in_valid5, in_ready5, out_valid5, out_ready5, sel_err5, err_clr5;
  logic [7:0]   out_data5;

  pipe_mux_nx1 #(.WIDTH(32), .N(4), .SELW(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus4), .sel(sel4),
    .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .sel_err(sel_err4),
    .err_clr(err_clr4)
  );

  pipe_mux_nx1 #(.WIDTH(32), .N(3), .SELW(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3),
    .err_clr(err_clr3)
  );

  pipe_mux_nx1 #(.WIDTH(8), .N(5), .SELW(3)) u5 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus5), .sel(sel5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .sel_err(sel_err5),
    .err_clr(err_clr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random run
  logic [7:0] q[$];
  bit         err_m;
  bit         acc_m, drn_m, hold_m;
  logic [7:0] d_m;
  logic [7:0] prev_data;
  int         beats;
  int         cyc;

  logic [31:0] exp4 [4];

  initial begin
    exp4 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    in_bus4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_bus3 = {32'h33333333, 32'h22222222, 32'h11111111};
    in_bus5 = '0;
    sel4 = '0; sel3 = '0; sel5 = '0;
    in_valid4 = 0; out_ready4 = 0; err_clr4 = 0;
    in_valid3 = 0; out_ready3 = 0; err_clr3 = 0;
    in_valid5 = 0; out_ready5 = 0; err_clr5 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    // Reset state
    chk("rst_out_valid", out_valid4, 1'b0);
    chk("rst_out_data", out_data4, 32'h0);
    chk("rst_in_ready", in_ready4, 1'b1);
    chk("rst_sel_err", sel_err4, 1'b0);
    #10 rst_n = 1'b1;
    tick();

    // Streaming, one beat per cycle, all select codes
    in_valid4 = 1; out_ready4 = 1; sel4 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stream_data%0d", i), out_data4, exp4[i]);
      chk($sformatf("stream_valid%0d", i), out_valid4, 1'b1);
      chk($sformatf("stream_ready%0d", i), in_ready4, 1'b1);
      chk($sformatf("stream_err%0d", i), sel_err4, 1'b0);
      if (i < 3) sel4 = 2'(i + 1);
      else in_valid4 = 0;
    end
    tick();
    chk("stream_drain_valid", out_valid4, 1'b0);

    // Backpressure: fill output register and skid
    out_ready4 = 0; in_valid4 = 1; sel4 = 2'd1;
    tick();
    chk("bp_b1_data", out_data4, 32'h22222222);
    chk("bp_b1_ready", in_ready4, 1'b1);
    sel4 = 2'd2;
    tick();
    chk("bp_b2_data", out_data4, 32'h22222222);
    chk("bp_b2_ready", in_ready4, 1'b0);
    sel4 = 2'd3;
    tick();
    chk("bp_hold_data", out_data4, 32'h22222222);
    chk("bp_hold_valid", out_valid4, 1'b1);
    chk("bp_hold_ready", in_ready4, 1'b0);
    out_ready4 = 1;
    tick();
    chk("bp_skid_data", out_data4, 32'h33333333);
    chk("bp_skid_ready", in_ready4, 1'b1);
    tick();
    chk("bp_b3_data", out_data4, 32'h44444444);
    chk("bp_b3_valid", out_valid4, 1'b1);
    in_valid4 = 0;
    tick();
    chk("bp_end_valid", out_valid4, 1'b0);
    chk("full_range_err", sel_err4, 1'b0);

    // Out-of-range select on N=3
    out_ready3 = 1; in_valid3 = 1; sel3 = 2'd3;
    tick();
    chk("oob_data", out_data3, 32'h0);
    chk("oob_valid", out_valid3, 1'b1);
    chk("oob_err", sel_err3, 1'b1);
    in_valid3 = 0;
    tick();
    chk("oob_sticky", sel_err3, 1'b1);
    err_clr3 = 1;
    tick();
    chk("oob_clear", sel_err3, 1'b0);
    in_valid3 = 1; sel3 = 2'd3;
    tick();
    chk("oob_set_wins", sel_err3, 1'b1);
    err_clr3 = 0; sel3 = 2'd2;
    tick();
    chk("oob_legal_data", out_data3, 32'h33333333);
    chk("oob_legal_err", sel_err3, 1'b1);
    in_valid3 = 0; err_clr3 = 1;
    tick();
    chk("oob_clear2", sel_err3, 1'b0);

    // Unaccepted illegal select must not set the flag
    err_clr3 = 0; out_ready3 = 0; in_valid3 = 1; sel3 = 2'd0;
    tick();
    sel3 = 2'd1;
    tick();
    chk("unacc_ready", in_ready3, 1'b0);
    sel3 = 2'd3;
    tick();
    chk("unacc_err", sel_err3, 1'b0);
    chk("unacc_data", out_data3, 32'h11111111);
    in_valid3 = 0; out_ready3 = 1;
    tick();
    chk("unacc_drain_data", out_data3, 32'h22222222);
    chk("unacc_drain_ready", in_ready3, 1'b1);
    out_ready3 = 0; in_valid3 = 1; sel3 = 2'd3;
    tick();
    chk("full_err", sel_err3, 1'b1);
    chk("full_ready", in_ready3, 1'b0);
    in_valid3 = 0;

    // Asynchronous reset with output and skid both full
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid3, 1'b0);
    chk("arst_data", out_data3, 32'h0);
    chk("arst_ready", in_ready3, 1'b1);
    chk("arst_err", sel_err3, 1'b0);
    #2 rst_n = 1'b1;
    in_valid3 = 1; sel3 = 2'd1; out_ready3 = 1;
    tick();
    chk("post_rst_data", out_data3, 32'h22222222);
    chk("post_rst_valid", out_valid3, 1'b1);
    in_valid3 = 0;
    tick();
    chk("post_rst_drain", out_valid3, 1'b0);

    // Random handshake against a FIFO scoreboard (N=5, WIDTH=8)
    err_m = 0;
    beats = 0;
    cyc = 0;
    while (beats < 1000 && cyc < 20000) begin
      in_valid5 = ($urandom_range(0, 9) < 6);
      out_ready5 = ($urandom_range(0, 9) < 6);
      sel5 = 3'($urandom);
      in_bus5 = {8'($urandom), 32'($urandom)};
      err_clr5 = ($urandom_range(0, 15) == 0);
      acc_m = in_valid5 && (q.size() < 2);
      drn_m = (q.size() > 0) && out_ready5;
      hold_m = (q.size() > 0) && !out_ready5;
      prev_data = out_data5;
      if (sel5 < 5) d_m = 8'(in_bus5 >> (sel5 * 8));
      else d_m = 8'h0;
      tick();
      cyc++;
      if (drn_m) void'(q.pop_front());
      if (acc_m) begin
        q.push_back(d_m);
        beats++;
      end
      if (acc_m && sel5 >= 5) err_m = 1;
      else if (err_clr5) err_m = 0;
      chk("rnd_valid", out_valid5, (q.size() > 0));
      chk("rnd_ready", in_ready5, (q.size() < 2));
      chk("rnd_err", sel_err5, err_m);
      if (q.size() > 0) chk("rnd_data", out_data5, q[0]);
      if (hold_m) chk("rnd_stable", out_data5, prev_data);
    end
    chk("rnd_beats", beats, 1000);
    in_valid5 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
